// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants and ALU operation encoding shared by the execute/memory slice
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;
endpackage

// File: rtl/mips_dmem.sv
// mips_dmem: word-addressed data memory, async clear, rising-edge write, combinational read
module mips_dmem #(
    parameter int DMEM_DEPTH = 64,
    parameter int DMEM_AW    = $clog2(DMEM_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [DMEM_AW-1:0] idx,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);
    logic [31:0] mem_q [DMEM_DEPTH];
    logic [31:0] mem_d [DMEM_DEPTH];
    // next memory image: current contents with the addressed word replaced on a store
    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[idx] = wdata;
    end
    // storage array; low reset wipes every word and blocks the write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DMEM_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end
    assign rdata = mem_q[idx];
endmodule

// File: rtl/mips_exec_mem_unit.sv
// mips_exec_mem_unit: single-cycle MIPS decode + ALU + data memory; DMEM_BOUNDS_CHECK_EN adds mem_fault
module mips_exec_mem_unit
    import mips_pkg::*;
#(
    parameter int DMEM_DEPTH = 64,
    parameter int DMEM_AW    = $clog2(DMEM_DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic [1:0]  alu_op,
`ifdef DMEM_BOUNDS_CHECK_EN
    output logic        mem_fault,
`endif
    output logic [31:0] alu_result,
    output logic        zero,
    output logic        branch_taken,
    output logic [31:0] mem_read_data,
    output logic [4:0]  write_reg,
    output logic [31:0] wb_data
);
    alu_op_e     op;
    logic [5:0]  funct;
    logic [31:0] imm;
    logic [31:0] opb;
    logic [31:0] rdata;
    logic        fault;
    logic        unused;
    assign funct = instr[5:0];
    // main controller: strobes and ALU op from opcode, R-type refined by funct
    always_comb begin
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        op         = ALU_ADD;
        case (instr[31:26])
            OP_RTYPE: begin
                reg_dst   = funct inside {F_ADD, F_SUB, F_AND, F_OR};
                reg_write = reg_dst;
                op        = funct == F_SUB ? ALU_SUB : funct == F_AND ? ALU_AND : funct == F_OR ? ALU_OR : ALU_ADD;
            end
            OP_LW: begin
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                mem_read   = 1'b1;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                branch = 1'b1;
                op     = ALU_SUB;
            end
            OP_ADDI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            default: ;
        endcase
    end
    assign alu_op = op;
    assign imm    = {{16{instr[15]}}, instr[15:0]};
    assign opb    = alu_src ? imm : rt_data;
    // 32-bit wrap-around ALU
    always_comb begin
        alu_result = op == ALU_SUB ? rs_data - opb : op == ALU_AND ? rs_data & opb : op == ALU_OR ? rs_data | opb : rs_data + opb;
    end
    assign zero         = alu_result == '0;
    assign branch_taken = branch & zero;
`ifdef DMEM_BOUNDS_CHECK_EN
    assign mem_fault = (mem_read | mem_write) && alu_result[31:DMEM_AW+2] != '0;
    assign fault     = mem_fault;
    assign unused    = ^{instr[25:21], alu_result[1:0]};
`else
    assign fault     = 1'b0;
    assign unused    = ^{instr[25:21], alu_result[1:0], alu_result[31:DMEM_AW+2]};
`endif
    mips_dmem #(.DMEM_DEPTH(DMEM_DEPTH), .DMEM_AW(DMEM_AW)) u_dmem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_write & ~fault),
        .idx   (alu_result[DMEM_AW+1:2]),
        .wdata (rt_data),
        .rdata (rdata)
    );
    assign mem_read_data = mem_read && !fault ? rdata : '0;
    assign write_reg     = reg_dst ? instr[15:11] : instr[20:16];
    assign wb_data       = mem_to_reg ? mem_read_data : alu_result;
endmodule

// File: tb/tb_mips_exec_mem_unit.sv
// tb_mips_exec_mem_unit: scoreboard bench for the execute/memory slice (default build, DMEM_BOUNDS_CHECK_EN optional)
module tb_mips_exec_mem_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        reg_dst, reg_write, alu_src, mem_to_reg, mem_read, mem_write, branch, zero, branch_taken;
    logic [1:0]  alu_op;
    logic [31:0] alu_result, mem_read_data, wb_data;
    logic [4:0]  write_reg;
`ifdef DMEM_BOUNDS_CHECK_EN
    logic        mem_fault;
`endif
    int n_chk = 0;
    int n_err = 0;
    typedef struct {
        string       name;
        logic [10:0] ctrl;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  wreg;
        logic [31:0] wb;
    } exp_t;
    exp_t sb[$];
    mips_exec_mem_unit dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src       (alu_src),
        .mem_to_reg    (mem_to_reg),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .branch        (branch),
        .alu_op        (alu_op),
`ifdef DMEM_BOUNDS_CHECK_EN
        .mem_fault     (mem_fault),
`endif
        .alu_result    (alu_result),
        .zero          (zero),
        .branch_taken  (branch_taken),
        .mem_read_data (mem_read_data),
        .write_reg     (write_reg),
        .wb_data       (wb_data)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask
    // ctrl = {reg_dst,reg_write,alu_src,mem_to_reg,mem_read,mem_write,branch,alu_op[1:0],zero,branch_taken}
    task automatic apply(input string name, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                         input logic [10:0] ctrl, input logic [31:0] alu, input logic [31:0] rd,
                         input logic [4:0] wr, input logic [31:0] wb);
        exp_t e;
        @(negedge clk);
        instr = i;
        rs_data = a;
        rt_data = b;
        e = '{name, ctrl, alu, rd, wr, wb};
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        check({e.name, ".ctrl"}, 32'({reg_dst, reg_write, alu_src, mem_to_reg, mem_read, mem_write, branch, alu_op, zero, branch_taken}), 32'(e.ctrl));
        check({e.name, ".alu"}, alu_result, e.alu);
        check({e.name, ".rdata"}, mem_read_data, e.rdata);
        check({e.name, ".wreg"}, 32'(write_reg), 32'(e.wreg));
        check({e.name, ".wb"}, wb_data, e.wb);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b1;
        apply("lw_reset", {6'h23, 5'd0, 5'd9, 16'd0}, 0, 0, 11'b0_1_1_1_1_0_0_00_1_0, 0, 0, 9, 0);
        apply("add", {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 5, 7, 11'b1_1_0_0_0_0_0_00_0_0, 12, 0, 3, 12);
        apply("sub", {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22}, 5, 7, 11'b1_1_0_0_0_0_0_01_0_0, 32'hFFFF_FFFE, 0, 3, 32'hFFFF_FFFE);
        apply("and", {6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h24}, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 11'b1_1_0_0_0_0_0_10_0_0, 32'h00F0_00F0, 0, 4, 32'h00F0_00F0);
        apply("or", {6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h25}, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 11'b1_1_0_0_0_0_0_11_0_0, 32'hFFF0_FFF0, 0, 4, 32'hFFF0_FFF0);
        apply("rbadfn", {6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h2A}, 5, 7, 11'b0_0_0_0_0_0_0_00_0_0, 12, 0, 2, 12);
        apply("sw", {6'h2B, 5'd0, 5'd10, 16'd8}, 0, 32'hDEAD_BEEF, 11'b0_0_1_0_0_1_0_00_0_0, 8, 0, 10, 8);
        apply("lw8", {6'h23, 5'd0, 5'd11, 16'd8}, 0, 0, 11'b0_1_1_1_1_0_0_00_0_0, 8, 32'hDEAD_BEEF, 11, 32'hDEAD_BEEF);
`ifndef DMEM_BOUNDS_CHECK_EN
        apply("lwwrap", {6'h23, 5'd0, 5'd11, 16'd8}, 256, 0, 11'b0_1_1_1_1_0_0_00_0_0, 32'h108, 32'hDEAD_BEEF, 11, 32'hDEAD_BEEF);
`endif
        apply("beq_eq", {6'h04, 5'd1, 5'd2, 16'h0010}, 32'h1234, 32'h1234, 11'b0_0_0_0_0_0_1_01_1_1, 0, 0, 2, 0);
        apply("beq_ne", {6'h04, 5'd1, 5'd2, 16'h0010}, 1, 2, 11'b0_0_0_0_0_0_1_01_0_0, 32'hFFFF_FFFF, 0, 2, 32'hFFFF_FFFF);
        apply("addi", {6'h08, 5'd1, 5'd4, 16'hFFFF}, 32'h10, 0, 11'b0_1_1_0_0_0_0_00_0_0, 32'hF, 0, 4, 32'hF);
        apply("nop3f", {6'h3F, 5'd1, 5'd2, 16'h0005}, 3, 4, 11'b0_0_0_0_0_0_0_00_0_0, 7, 0, 2, 7);
        apply("sw_rst", {6'h2B, 5'd0, 5'd10, 16'd8}, 0, 32'h1111_1111, 11'b0_0_1_0_0_1_0_00_0_0, 8, 0, 10, 8);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        apply("lw_after", {6'h23, 5'd0, 5'd11, 16'd8}, 0, 0, 11'b0_1_1_1_1_0_0_00_0_0, 8, 0, 11, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
